// File: rtl/cpu_pkg.sv
// Shared CPU definitions: machine word width, word type and the default
// number of A bits that address the data RAM.
package cpu_pkg;

  localparam int WORD_WIDTH     = 16;
  localparam int RAM_ADDR_WIDTH = 8;

  typedef logic [WORD_WIDTH-1:0] word_t;

endpackage : cpu_pkg

// File: rtl/regst_rn.sv
// Store-enable register with asynchronous active-low clear.
// Loads d on a rising edge when st is high, otherwise holds.
module regst_rn
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next value: take the new data on a store, otherwise keep the current value.
  always_comb begin
    q_d = q_q;
    if (st) begin
      q_d = d;
    end else begin
      q_d = q_q;
    end
  end

  // State register, cleared immediately when rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= {WIDTH{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign out = q_q;

endmodule : regst_rn

// File: rtl/combined_memory.sv
// CPU data-memory stage: A register, D register and a word-addressed RAM
// indexed by the low bits of A. The ALU result x can be captured into any
// combination of A, D and RAM[A]; A, D and RAM[A] are fed back to the
// operand mux. The RAM read is combinational so it follows A without delay.
module combined_memory
  import cpu_pkg::*;
#(
  parameter int WIDTH      = WORD_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st_a,
  input  logic             st_d,
  input  logic             st_am,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] am_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // The RAM address is a slice of A, so it must fit inside the word.
  if ((ADDR_WIDTH < 1) || (ADDR_WIDTH > WIDTH)) begin : g_param_check
    $error("combined_memory: ADDR_WIDTH must satisfy 1 <= ADDR_WIDTH <= WIDTH");
  end

  logic [WIDTH-1:0]      a_val;
  logic [WIDTH-1:0]      d_val;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [WIDTH-1:0]      mem_q [DEPTH];

  regst_rn #(.WIDTH(WIDTH)) u_reg_a (
    .clk   (clk),
    .rst_n (rst_n),
    .st    (st_a),
    .d     (x),
    .out   (a_val)
  );

  regst_rn #(.WIDTH(WIDTH)) u_reg_d (
    .clk   (clk),
    .rst_n (rst_n),
    .st    (st_d),
    .d     (x),
    .out   (d_val)
  );

  // Upper A bits are ignored, so addresses alias modulo the RAM depth.
  assign ram_addr = a_val[ADDR_WIDTH-1:0];

  // RAM writes are suppressed while reset is held so a pending store is dropped.
  always_comb begin
    ram_we = 1'b0;
    if (rst_n && st_am) begin
      ram_we = 1'b1;
    end else begin
      ram_we = 1'b0;
    end
  end

  // RAM write port: addressed by the A value before this edge, never by the new x.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_addr] <= x;
    end
  end

  assign a_out  = a_val;
  assign d_out  = d_val;
  assign am_out = mem_q[ram_addr];

endmodule : combined_memory

// File: doc/combined_memory.md
Name: combined_memory

Overview:
- CPU data-memory stage that holds the A register, the D register and a word-addressed RAM addressed by A.
- It captures the ALU result X into any combination of A, D and *A (RAM[A]) on the clock edge, and presents A, D and *A back to the ALU operand mux.
- It sits directly downstream of the ALU and upstream of the operand select. Each register is built from a resettable store-enable register sub-module.

Parameters:
- WIDTH, 16, data word width in bits for A, D, X and RAM words.
- ADDR_WIDTH, 8, number of low A bits used as the RAM address; RAM depth is 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- st_a  input  1  store X into A at the next rising edge.
- st_d  input  1  store X into D at the next rising edge.
- st_am  input  1  store X into RAM[A] at the next rising edge.
- x  input  WIDTH  write data (ALU result).
- a_out  output  WIDTH  current A register value.
- d_out  output  WIDTH  current D register value.
- am_out  output  WIDTH  RAM[a_out[ADDR_WIDTH-1:0]], combinational read.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- Reset:
  - rst_n low clears A and D to 0 immediately, without waiting for a clock edge.
  - While rst_n is low, all stores are ignored, including RAM writes.
  - RAM contents are not cleared by reset. am_out after reset is RAM[0], which is undefined until written.
- Store (rst_n high, rising clk):
  - A <= x if st_a.
  - D <= x if st_d.
  - RAM[A_old[ADDR_WIDTH-1:0]] <= x if st_am.
  - Any combination of the three strobes may be asserted in the same cycle.
- Simultaneous st_a and st_am:
  - The RAM write uses the A value from before the edge (A_old), never the new x.
  - After the edge, am_out reads RAM at the new A.
- Latency:
  - a_out and d_out are registered and change one edge after the store.
  - am_out is a combinational read of the RAM array. It updates in the same cycle A changes, with no clock delay.
- Read-during-write:
  - Before the edge, am_out shows the old word.
  - After the edge, if A is unchanged, am_out shows x.
  - No bypass of x to am_out before the edge.
- Address width:
  - A bits [WIDTH-1:ADDR_WIDTH] are ignored for RAM addressing, so addresses alias modulo 2**ADDR_WIDTH.
  - a_out still reports the full WIDTH value.
- No strobes asserted: all state holds indefinitely.
- Reset asserted mid-cycle: A and D clear immediately. A pending store in that cycle is dropped.
- Reset release: the first edge with rst_n high performs stores normally. rst_n is externally synchronised on deassertion.
- Elaboration checks: 1 <= ADDR_WIDTH <= WIDTH, enforced with an elaboration assertion.

Decomposition:
- Shared package cpu_pkg:
  - WORD_WIDTH = 16.
  - typedef logic [WORD_WIDTH-1:0] word_t.
  - RAM_ADDR_WIDTH default constant.
- Sub-module regst_rn: a WIDTH-bit register with clk, rst_n, st, d, out; async clear to 0; load on st. It is instantiated for A and for D.
- RAM is an inline array in combined_memory with one synchronous write port and one asynchronous read port.

Test Plan:
- Reset: rst_n=0 with st_a=st_d=1, x=16'hFFFF across edges -> a_out=0, d_out=0; stores ignored.
- Independent stores:
  - x=16'h0005, st_a -> a_out=5.
  - Then x=16'h1234, st_am -> am_out=16'h1234.
  - Then x=16'h00AA, st_d -> d_out=16'h00AA; a_out and am_out unchanged.
- Simultaneous store with A=5:
  - x=16'h0009 with st_a=st_am=1 -> RAM[5]=9 and a_out=9.
  - am_out then shows RAM[9]; re-setting A=5 shows am_out=9.
- Aliasing (ADDR_WIDTH=8):
  - A=16'h0103, st_am with x=16'hBEEF.
  - Then A=16'h0003 -> am_out=16'hBEEF.
- Mid-operation reset:
  - A=7, D=3; drop rst_n between edges -> a_out and d_out go to 0 before the next edge.
  - An st_am pulse during reset leaves RAM[7] unchanged.
- Hold: 20 cycles with no strobes and random x -> a_out, d_out, am_out constant.
